// File: rtl/gray_pkg.sv
// Shared types, constants and helpers for the gray code monitor.
// FSM states, error cause codes, gray2bin and popcount.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MULTI = 2'b01;
  localparam logic [1:0] ERR_STEP  = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

  // Operates on 8 bits; narrower codes are zero-extended, which
  // leaves the low bits of the result unchanged.
  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary converter, W bits (2..8).
// Ports: gray (in, W), bin (out, W).
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  logic [7:0] ext;

  always_comb begin
    ext = gray2bin(8'(gray));
    bin = ext[W-1:0];
  end

endmodule

// File: rtl/gray_monitor.sv
// Checks a gray counter stream: converts, verifies +1 steps, counts wraps.
// Ports: Clk, Reset(n), Valid, Gray, Ovf_in, Clear -> Bin, Bin_valid, Wrap_count, Err, Err_code, Locked.
module gray_monitor
  import gray_pkg::*;
#(
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Valid,
  input  logic [W-1:0]  Gray,
  input  logic          Ovf_in,
  input  logic          Clear,
  output logic [W-1:0]  Bin,
  output logic          Bin_valid,
  output logic [CW-1:0] Wrap_count,
  output logic          Err,
  output logic [1:0]    Err_code,
  output logic          Locked
);

  localparam logic [W-1:0]  BMAX = '1;
  localparam logic [CW-1:0] WMAX = '1;

  state_t        state_q, state_d;
  logic [W-1:0]  prev_gray_q, prev_gray_d;
  logic [W-1:0]  prev_bin_q, prev_bin_d;
  logic          ovf_seen_q, ovf_seen_d;
  logic [W-1:0]  bin_q, bin_d;
  logic          bin_valid_q, bin_valid_d;
  logic [CW-1:0] wrap_q, wrap_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic [W-1:0]  g_bin;
  logic [1:0]    cause;

  gray_to_bin #(.W(W)) u_g2b (
    .gray (Gray),
    .bin  (g_bin)
  );

  // Cause of a TRACK-state violation; first match wins.
  always_comb begin
    cause = ERR_NONE;
    if (popcount(8'(Gray ^ prev_gray_q)) != 4'd1) begin
      cause = ERR_MULTI;
    end else if (g_bin != prev_bin_q + W'(1)) begin
      cause = ERR_STEP;
    end else if (!ovf_seen_q && Ovf_in && prev_bin_q != BMAX) begin
      cause = ERR_OVF;
    end else if (ovf_seen_q && !Ovf_in) begin
      cause = ERR_OVF;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_gray_d = prev_gray_q;
    prev_bin_d  = prev_bin_q;
    ovf_seen_d  = ovf_seen_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    wrap_d      = wrap_q;
    err_d       = err_q;
    code_d      = code_q;
    if (Clear) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      wrap_d  = '0;
    end else if (Valid) begin
      bin_d       = g_bin;
      bin_valid_d = 1'b1;
      prev_gray_d = Gray;
      prev_bin_d  = g_bin;
      ovf_seen_d  = Ovf_in;
      case (state_q)
        ST_IDLE: state_d = ST_TRACK;
        ST_TRACK: begin
          if (cause != ERR_NONE) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            code_d  = cause;
          end else if (prev_bin_q == BMAX && wrap_q != WMAX) begin
            wrap_d = wrap_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      prev_gray_q <= '0;
      prev_bin_q  <= '0;
      ovf_seen_q  <= 1'b0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      wrap_q      <= '0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      prev_gray_q <= prev_gray_d;
      prev_bin_q  <= prev_bin_d;
      ovf_seen_q  <= ovf_seen_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign Bin        = bin_q;
  assign Bin_valid  = bin_valid_q;
  assign Wrap_count = wrap_q;
  assign Err        = err_q;
  assign Err_code   = code_q;
  assign Locked     = (state_q == ST_TRACK);

endmodule

// File: tb/tb_gray_monitor.sv
// Self-checking bench for gray_monitor (W=3, CW=8).
// Scoreboard for Bin pulses plus per-scenario status checks.
module tb_gray_monitor;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Valid = 1'b0;
  logic [2:0] Gray = 3'b000;
  logic       Ovf_in = 1'b0;
  logic       Clear = 1'b0;
  logic [2:0] Bin;
  logic       Bin_valid;
  logic [7:0] Wrap_count;
  logic       Err;
  logic [1:0] Err_code;
  logic       Locked;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [2:0] exp_q[$];

  gray_monitor #(.W(3), .CW(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Valid      (Valid),
    .Gray       (Gray),
    .Ovf_in     (Ovf_in),
    .Clear      (Clear),
    .Bin        (Bin),
    .Bin_valid  (Bin_valid),
    .Wrap_count (Wrap_count),
    .Err        (Err),
    .Err_code   (Err_code),
    .Locked     (Locked)
  );

  always #5 Clk = ~Clk;

  function automatic logic [2:0] m_g2b(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

  function automatic logic [2:0] b2g(input int n);
    logic [2:0] b;
    b = 3'(n);
    return b ^ (b >> 1);
  endfunction

  always @(negedge Clk) begin : mon
    logic [2:0] e;
    if (Bin_valid) begin
      pulses++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: Bin_valid=1 Bin=%0d, no pulse expected", Bin);
      end else begin
        e = exp_q.pop_front();
        if (Bin !== e) begin
          bad++;
          $display("FAIL sb_bin: Bin=%0d want %0d", Bin, e);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] g,
                       input logic o, input logic c);
    @(negedge Clk);
    Valid = v;
    Gray = g;
    Ovf_in = o;
    Clear = c;
    if (v && !c) exp_q.push_back(m_g2b(g));
    @(posedge Clk);
    #1;
    Valid = 1'b0;
    Clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({Bin, Bin_valid, Wrap_count, Err, Err_code, Locked} !== 16'h0) begin
      bad++;
      $display("FAIL reset: outs=%h want 0",
               {Bin, Bin_valid, Wrap_count, Err, Err_code, Locked});
    end
    @(negedge Clk);
    #2;
    Reset = 1'b1;
  endtask

  task automatic test_sequence();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 9; i++) drive(1'b1, b2g(i % 8), i == 8, 1'b0);
    total++;
    if ({Wrap_count, Err, Locked} !== {8'd1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL seq_status: wrap=%0d err=%b lock=%b want 1 0 1",
               Wrap_count, Err, Locked);
    end
    drive(1'b0, 3'b000, 1'b1, 1'b0);
    total++;
    if (Bin_valid !== 1'b0 || Err !== 1'b0) begin
      bad++;
      $display("FAIL seq_hold: bv=%b err=%b want 0 0", Bin_valid, Err);
    end
    @(negedge Clk);
    #1;
    total++;
    if (pulses - p0 != 9 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL seq_pulses: got %0d left %0d want 9 0",
               pulses - p0, exp_q.size());
    end
  endtask

  task automatic test_multi();
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 1'b0, 1'b0);
    drive(1'b1, 3'b111, 1'b0, 1'b0);
    total++;
    if ({Err, Err_code, Bin, Locked} !== {1'b1, 2'b01, 3'd5, 1'b0}) begin
      bad++;
      $display("FAIL multi: err=%b code=%b bin=%0d lock=%b want 1 01 5 0",
               Err, Err_code, Bin, Locked);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    total++;
    if ({Bin, Bin_valid, Wrap_count, Err, Err_code, Locked} !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: outs=%h want 0",
               {Bin, Bin_valid, Wrap_count, Err, Err_code, Locked});
    end
    repeat (2) @(negedge Clk);
    #2;
    Reset = 1'b1;
  endtask

  task automatic test_step();
    logic [2:0] g;
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 1'b0, 1'b0);
    drive(1'b1, 3'b011, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 1'b0, 1'b0);
    total++;
    if ({Err, Err_code} !== {1'b1, 2'b10}) begin
      bad++;
      $display("FAIL step: err=%b code=%b want 1 10", Err, Err_code);
    end
    for (int k = 0; k < 11; k++) begin
      g = b2g(k * 3);
      drive(1'b1, g, k[0], 1'b0);
    end
    total++;
    if ({Err, Err_code, Wrap_count, Locked} !== {1'b1, 2'b10, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL step_frozen: err=%b code=%b wrap=%0d lock=%b want 1 10 0 0",
               Err, Err_code, Wrap_count, Locked);
    end
  endtask

  task automatic test_repeat();
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    drive(1'b1, 3'b010, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 1'b0, 1'b0);
    total++;
    if ({Err, Err_code} !== {1'b1, 2'b01}) begin
      bad++;
      $display("FAIL repeat: err=%b code=%b want 1 01", Err, Err_code);
    end
  endtask

  task automatic test_ovf();
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, b2g(i), 1'b0, 1'b0);
    drive(1'b1, 3'b110, 1'b1, 1'b0);
    total++;
    if ({Err, Err_code, Bin} !== {1'b1, 2'b11, 3'd4}) begin
      bad++;
      $display("FAIL ovf_rise: err=%b code=%b bin=%0d want 1 11 4",
               Err, Err_code, Bin);
    end
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    drive(1'b1, 3'b000, 1'b1, 1'b0);
    drive(1'b1, 3'b001, 1'b1, 1'b0);
    drive(1'b1, 3'b011, 1'b0, 1'b0);
    total++;
    if ({Err, Err_code} !== {1'b1, 2'b11}) begin
      bad++;
      $display("FAIL ovf_fall: err=%b code=%b want 1 11", Err, Err_code);
    end
  endtask

  task automatic test_clear_valid();
    drive(1'b1, 3'b111, 1'b0, 1'b1);
    total++;
    if ({Locked, Err, Err_code, Wrap_count, Bin_valid, Bin} !==
        {1'b0, 1'b0, 2'b00, 8'd0, 1'b0, 3'd2}) begin
      bad++;
      $display("FAIL clr_valid: lock=%b err=%b code=%b wrap=%0d bv=%b bin=%0d want 0 0 00 0 0 2",
               Locked, Err, Err_code, Wrap_count, Bin_valid, Bin);
    end
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    for (int n = 1; n <= 2400; n++) begin
      drive(1'b1, b2g(n % 8), n >= 8, 1'b0);
      if (n == 800 || n == 2040) begin
        total++;
        if (Wrap_count !== 8'(n / 8)) begin
          bad++;
          $display("FAIL wrap_%0d: got %0d want %0d", n, Wrap_count, n / 8);
        end
      end
    end
    total++;
    if ({Wrap_count, Err, Locked} !== {8'd255, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL wrap_sat: wrap=%0d err=%b lock=%b want 255 0 1",
               Wrap_count, Err, Locked);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_multi();
    test_reset_mid();
    test_step();
    test_repeat();
    test_ovf();
    test_clear_valid();
    @(negedge Clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_missing: %0d pulses never seen, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
